// File: rtl/ysyx_22050078_ifu_pkg.sv
// Shared widths, reset constants, FSM encoding and the fetch-queue payload for the IFU.
package ysyx_22050078_ifu_pkg;

    localparam int unsigned PC_WIDTH   = 64;
    localparam int unsigned INST_WIDTH = 32;
    localparam int unsigned Q_DEPTH    = 2;

    localparam logic [PC_WIDTH-1:0]   IFU_RESET_PC = 64'h8000_0000;
    localparam logic [INST_WIDTH-1:0] INST_NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_DROP = 3'd3,
        ST_HALT = 3'd4
    } ifu_state_e;

    typedef struct packed {
        logic                  err;
        logic [PC_WIDTH-1:0]   pc;
        logic [INST_WIDTH-1:0] inst;
    } ifu_entry_t;

    // A faulting entry carries a NOP so the decoder never sees garbage bits.
    function automatic ifu_entry_t fault_entry(input logic [PC_WIDTH-1:0] pc);
        ifu_entry_t e;
        e.err  = 1'b1;
        e.pc   = pc;
        e.inst = INST_NOP;
        return e;
    endfunction

endpackage

// File: rtl/ysyx_22050078_ifu_if.sv
// IFU boundary: instruction-memory request/response, redirect, and decoder handshake.
interface ysyx_22050078_ifu_if;
    import ysyx_22050078_ifu_pkg::*;

    logic                  req_valid;
    logic                  req_ready;
    logic [PC_WIDTH-1:0]   addr;
    logic                  rsp_valid;
    logic [INST_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic                  redirect_valid;
    logic [PC_WIDTH-1:0]   redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   inst_pc;
    logic                  inst_err;
    logic                  halted;

    modport master (
        output req_valid, addr, inst_valid, inst, inst_pc, inst_err, halted,
        input  req_ready, rsp_valid, rsp_data, rsp_err, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  req_valid, addr, inst_valid, inst, inst_pc, inst_err, halted,
        output req_ready, rsp_valid, rsp_data, rsp_err, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/ysyx_22050078_ifu_queue.sv
// Synchronous FIFO of fetched entries; flush empties it and may load one entry on the same edge.
module ysyx_22050078_ifu_queue
    import ysyx_22050078_ifu_pkg::*;
#(
    parameter int unsigned DEPTH = Q_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  ifu_entry_t               push_entry,
    input  logic                     pop,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    ifu_entry_t      mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count_q;
    logic            do_push;
    logic            do_pop;

    // A pop frees its slot before the push lands, so push-when-full is legal alongside a pop.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q < CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= push ? AW'(1) : '0;
            count_q <= push ? CW'(1) : '0;
            if (push) begin
                mem[0] <= push_entry;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: owns the fetch PC, keeps one memory request in flight, queues responses.
module ysyx_22050078_ifu
    import ysyx_22050078_ifu_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = IFU_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    ysyx_22050078_ifu_if.master      bus
);

    localparam int unsigned QCW = $clog2(Q_DEPTH) + 1;

    ifu_state_e          state_q, state_n;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_n;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_n;
    logic                outstanding_q, outstanding_n;
    logic                req_valid_q;
    logic [PC_WIDTH-1:0] addr_q;
    logic                halted_q;

    logic                q_flush;
    logic                q_push;
    ifu_entry_t          q_push_entry;
    logic                q_pop;
    ifu_entry_t          q_head;
    logic [QCW-1:0]      q_count;
    logic                q_empty;
    logic [QCW:0]        occupancy;
    logic                req_fire;
    logic                inst_valid_c;

    ysyx_22050078_ifu_queue #(.DEPTH(Q_DEPTH)) u_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (q_flush),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head       (q_head),
        .count      (q_count),
        .empty      (q_empty)
    );

    assign req_fire     = req_valid_q && bus.req_ready;
    assign occupancy    = {1'b0, q_count} + (QCW+1)'(outstanding_q);
    assign inst_valid_c = !q_empty && !bus.redirect_valid;
    assign q_pop        = inst_valid_c && bus.inst_ready;

    // Next-state, fetch PC and queue-push decisions; a redirect overrides every state.
    always_comb begin
        state_n       = state_q;
        fetch_pc_n    = fetch_pc_q;
        req_pc_n      = req_pc_q;
        outstanding_n = outstanding_q;
        q_flush       = 1'b0;
        q_push        = 1'b0;
        q_push_entry  = '0;

        if (req_fire) begin
            outstanding_n = 1'b1;
        end else if (bus.rsp_valid) begin
            outstanding_n = 1'b0;
        end

        if (bus.redirect_valid) begin
            q_flush    = 1'b1;
            fetch_pc_n = bus.redirect_pc;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                q_push       = 1'b1;
                q_push_entry = fault_entry(bus.redirect_pc);
                state_n      = ST_HALT;
            end else if (req_fire || (outstanding_q && !bus.rsp_valid)) begin
                // A stale response is still owed by memory; swallow it before fetching again.
                state_n = ST_DROP;
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (occupancy < (QCW+1)'(Q_DEPTH)) begin
                        state_n = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc_n   = fetch_pc_q;
                        fetch_pc_n = fetch_pc_q + PC_WIDTH'(4);
                        state_n    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.rsp_valid) begin
                        q_push = 1'b1;
                        if (bus.rsp_err) begin
                            q_push_entry = fault_entry(req_pc_q);
                            state_n      = ST_HALT;
                        end else begin
                            q_push_entry.err  = 1'b0;
                            q_push_entry.pc   = req_pc_q;
                            q_push_entry.inst = bus.rsp_data;
                            state_n           = ST_IDLE;
                        end
                    end
                end
                ST_DROP: begin
                    if (bus.rsp_valid) begin
                        state_n = ST_IDLE;
                    end
                end
                ST_HALT: begin
                    state_n = ST_HALT;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= '0;
            outstanding_q <= 1'b0;
            req_valid_q   <= 1'b0;
            addr_q        <= '0;
            halted_q      <= 1'b0;
        end else begin
            state_q       <= state_n;
            fetch_pc_q    <= fetch_pc_n;
            req_pc_q      <= req_pc_n;
            outstanding_q <= outstanding_n;
            req_valid_q   <= (state_n == ST_REQ);
            addr_q        <= (state_n == ST_REQ) ? fetch_pc_n : '0;
            halted_q      <= (state_n == ST_HALT);
        end
    end

    assign bus.req_valid  = req_valid_q;
    assign bus.addr       = addr_q;
    assign bus.halted     = halted_q;
    assign bus.inst_valid = inst_valid_c;
    assign bus.inst       = q_head.inst;
    assign bus.inst_pc    = q_head.pc;
    assign bus.inst_err   = q_head.err;

endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// Directed bench for the IFU: in-order fetch, back-pressure, redirects, faults and PC wrap.
module tb_ysyx_22050078_ifu;

    logic clk;
    logic rst;

    ysyx_22050078_ifu_if bus ();

    ysyx_22050078_ifu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int fires;
    logic        auto_rsp;
    logic        pend;
    logic [63:0] pend_addr;
    logic [63:0] err_addr;
    logic [63:0] got_pc   [$];
    logic [31:0] got_inst [$];
    logic        got_err  [$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample handshakes before the edge, then play memory and clear the redirect pulse.
    task automatic cycle();
        logic        fire_now;
        logic [63:0] fa;
        #1;
        fire_now = bus.req_valid && bus.req_ready;
        fa       = bus.addr;
        if (bus.inst_valid && bus.inst_ready) begin
            got_pc.push_back(bus.inst_pc);
            got_inst.push_back(bus.inst);
            got_err.push_back(bus.inst_err);
        end
        if (fire_now) fires++;
        @(posedge clk);
        #1;
        bus.rsp_valid      = 1'b0;
        bus.rsp_err        = 1'b0;
        bus.redirect_valid = 1'b0;
        if (fire_now) begin
            pend      = 1'b1;
            pend_addr = fa;
        end
        if (pend && auto_rsp) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_data  = inst_of(pend_addr);
            bus.rsp_err   = (pend_addr == err_addr);
            pend          = 1'b0;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gbase;
        int f0;
        checks   = 0;
        failures = 0;
        fires    = 0;
        auto_rsp = 1'b1;
        pend     = 1'b0;
        pend_addr = '0;
        err_addr = 64'h1;
        rst      = 1'b1;
        bus.req_ready      = 1'b1;
        bus.rsp_valid      = 1'b0;
        bus.rsp_data       = '0;
        bus.rsp_err        = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b1;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(bus.req_valid), 64'h0);
        chk("rst_addr", bus.addr, 64'h0);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
        chk("rst_halted", 64'(bus.halted), 64'h0);
        chk("rst_inst_pc", bus.inst_pc, 64'h0);
        rst = 1'b0;
        #1;
        chk("idle_req_valid", 64'(bus.req_valid), 64'h0);

        // 1: first request after one IDLE cycle, response visible the cycle after it arrives
        cycle();
        chk("t1_req_valid", 64'(bus.req_valid), 64'h1);
        chk("t1_addr", bus.addr, 64'h8000_0000);
        cycle();
        chk("t1_wait_req_valid", 64'(bus.req_valid), 64'h0);
        chk("t1_wait_inst_valid", 64'(bus.inst_valid), 64'h0);
        cycle();
        chk("t1_inst_valid", 64'(bus.inst_valid), 64'h1);
        chk("t1_inst_pc", bus.inst_pc, 64'h8000_0000);
        chk("t1_inst", 64'(bus.inst), 64'(inst_of(64'h8000_0000)));
        for (int i = 0; i < 40 && got_pc.size() < 3; i++) cycle();
        chk("t1_timeout", 64'(got_pc.size() >= 3), 64'h1);
        if (got_pc.size() >= 3) begin
            chk("t1_pc0", got_pc[0], 64'h8000_0000);
            chk("t1_pc1", got_pc[1], 64'h8000_0004);
            chk("t1_pc2", got_pc[2], 64'h8000_0008);
            chk("t1_inst2", 64'(got_inst[2]), 64'(inst_of(64'h8000_0008)));
            chk("t1_err2", 64'(got_err[2]), 64'h0);
        end

        // 2: decoder stalled -> two entries held, fetch stops, nothing lost
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        chk("t2_req_valid", 64'(bus.req_valid), 64'h0);
        chk("t2_inst_valid", 64'(bus.inst_valid), 64'h1);
        chk("t2_head_pc", bus.inst_pc, 64'h8000_000C);
        bus.inst_ready = 1'b1;
        cycle();
        cycle();
        bus.inst_ready = 1'b0;
        #1;
        chk("t2_drained", 64'(bus.inst_valid), 64'h0);
        chk("t2_count", 64'(got_pc.size()), 64'd5);
        if (got_pc.size() >= 5) begin
            chk("t2_pc3", got_pc[3], 64'h8000_000C);
            chk("t2_pc4", got_pc[4], 64'h8000_0010);
        end
        bus.inst_ready = 1'b1;
        for (int i = 0; i < 40 && got_pc.size() < 6; i++) cycle();
        chk("t2_timeout", 64'(got_pc.size() >= 6), 64'h1);
        if (got_pc.size() >= 6) chk("t2_pc5", got_pc[5], 64'h8000_0014);

        // 3: redirect while waiting on memory drops the old response
        auto_rsp = 1'b0;
        for (int i = 0; i < 20 && !pend; i++) cycle();
        chk("t3_wait_reached", 64'(pend), 64'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0100;
        #1;
        chk("t3_valid_masked", 64'(bus.inst_valid), 64'h0);
        err_addr = 64'h8000_0108;
        cycle();
        gbase = got_pc.size();
        chk("t3_flushed", 64'(bus.inst_valid), 64'h0);
        chk("t3_no_req", 64'(bus.req_valid), 64'h0);
        auto_rsp = 1'b1;

        // 4: access fault at 8000_0108 halts fetch
        for (int i = 0; i < 60 && got_pc.size() < gbase + 3; i++) cycle();
        chk("t4_timeout", 64'(got_pc.size() >= gbase + 3), 64'h1);
        if (got_pc.size() >= gbase + 3) begin
            chk("t3_first_pc", got_pc[gbase], 64'h8000_0100);
            chk("t3_first_inst", 64'(got_inst[gbase]), 64'(inst_of(64'h8000_0100)));
            chk("t4_pc1", got_pc[gbase+1], 64'h8000_0104);
            chk("t4_err_pc", got_pc[gbase+2], 64'h8000_0108);
            chk("t4_err_flag", 64'(got_err[gbase+2]), 64'h1);
            chk("t4_err_inst", 64'(got_inst[gbase+2]), 64'h0000_0013);
        end
        chk("t4_halted", 64'(bus.halted), 64'h1);
        f0 = fires;
        for (int i = 0; i < 8; i++) cycle();
        chk("t4_no_fetch", 64'(fires - f0), 64'h0);
        chk("t4_req_low", 64'(bus.req_valid), 64'h0);
        chk("t4_still_halted", 64'(bus.halted), 64'h1);

        // 5: misaligned redirect faults immediately; aligned redirect resumes in two cycles
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0102;
        cycle();
        chk("t5_halted", 64'(bus.halted), 64'h1);
        chk("t5_valid", 64'(bus.inst_valid), 64'h1);
        chk("t5_pc", bus.inst_pc, 64'h8000_0102);
        chk("t5_err", 64'(bus.inst_err), 64'h1);
        chk("t5_inst", 64'(bus.inst), 64'h0000_0013);
        chk("t5_no_req", 64'(bus.req_valid), 64'h0);
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0200;
        cycle();
        chk("t5_idle_req", 64'(bus.req_valid), 64'h0);
        chk("t5_unhalted", 64'(bus.halted), 64'h0);
        chk("t5_empty", 64'(bus.inst_valid), 64'h0);
        cycle();
        chk("t5_req_valid", 64'(bus.req_valid), 64'h1);
        chk("t5_addr", bus.addr, 64'h8000_0200);

        // 6: request held stable under memory back-pressure; redirect with response drops it
        bus.req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t6_hold_valid", 64'(bus.req_valid), 64'h1);
            chk("t6_hold_addr", bus.addr, 64'h8000_0200);
        end
        bus.req_ready = 1'b1;
        cycle();
        chk("t6_rsp_present", 64'(bus.rsp_valid), 64'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h8000_0300;
        cycle();
        chk("t6_rsp_dropped", 64'(bus.inst_valid), 64'h0);
        chk("t6_idle", 64'(bus.req_valid), 64'h0);
        gbase = got_pc.size();
        cycle();
        chk("t6_new_addr", bus.addr, 64'h8000_0300);
        for (int i = 0; i < 30 && got_pc.size() <= gbase; i++) cycle();
        chk("t6_timeout", 64'(got_pc.size() > gbase), 64'h1);
        if (got_pc.size() > gbase) chk("t6_first_pc", got_pc[gbase], 64'h8000_0300);

        // Fetch PC wraps modulo 2^64
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        cycle();
        gbase = got_pc.size();
        for (int i = 0; i < 40 && got_pc.size() < gbase + 2; i++) cycle();
        chk("wrap_timeout", 64'(got_pc.size() >= gbase + 2), 64'h1);
        if (got_pc.size() >= gbase + 2) begin
            chk("wrap_pc0", got_pc[gbase], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_pc1", got_pc[gbase+1], 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
